// File: rtl/div_seq_ctrl_if.sv
// Handshake bundle between the EX stage (master) and the divide sequencer (slave).
interface div_seq_ctrl_if #(parameter int WIDTH = 32);
    logic               start_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU; stalls EX until {rem, quo} is ready.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    div_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_DIVZERO, S_END} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem, dvd, dsr;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff, rem_n, dvd_n, q_fin, r_fin;
    logic               ge, last;

    // Magnitudes stay unsigned W-bit, so |0x80000000| needs no extra bit.
    assign abs1 = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign abs2 = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // One restoring step: compare on W+1 bits, subtract modulo 2^W (exact when ge).
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dsr});
    assign diff   = rem_sh[WIDTH-1:0] - dsr;
    assign rem_n  = ge ? diff : rem_sh[WIDTH-1:0];
    assign dvd_n  = {dvd[WIDTH-2:0], ge};
    assign q_fin  = neg_q ? -dvd_n : dvd_n;
    assign r_fin  = neg_r ? -rem_n : rem_n;
    assign last   = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.annul_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.start_i)
                               state_nxt = (bus.opdata2_i == '0) ? S_DIVZERO : S_ON;
                S_ON:      if (last) state_nxt = S_END;
                S_DIVZERO: state_nxt = S_END;
                S_END:     if (!bus.start_i) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready_o  = (state == S_END);
        bus.stall_o  = ~rst & bus.start_i & ~bus.annul_i & (state != S_END);
        bus.result_o = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else if (bus.annul_i) begin
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_q <= '0;
                    if (bus.start_i) begin
                        dvd   <= abs1;
                        dsr   <= abs2;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_r <= bus.signed_i & bus.opdata1_i[WIDTH-1];
                    end
                end
                S_ON: begin
                    rem <= rem_n;
                    dvd <= dvd_n;
                    cnt <= cnt + CNT_W'(1);
                    if (last) result_q <= {r_fin, q_fin};
                end
                S_DIVZERO: result_q <= '0;
                S_END:     if (!bus.start_i) result_q <= '0;
                default:   result_q <= '0;
            endcase
        end
    end
endmodule
